alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares one combinational ALU (`alu_riscv`) between two requesters, such as the execute stage and a branch/address unit. Operand requests are accepted through valid/ready handshakes and granted round-robin. The registered result and flag return on a single tagged response channel one cycle after acceptance. A one-entry output register gives full throughput when the consumer is always ready.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand/result width; forwarded to `alu_riscv`.

Ports:
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `req_valid_i`  in  [1:0]  per-requester request valid.
- `req_ready_o`  out  [1:0]  per-requester accept; at most one bit high.
- `req_a_i`  in  [1:0][DATA_WIDTH-1:0]  operand A per requester.
- `req_b_i`  in  [1:0][DATA_WIDTH-1:0]  operand B per requester.
- `req_op_i`  in  [1:0][4:0]  ALU opcode per requester, `alu_opcodes_pkg` encoding.
- `resp_valid_o`  out  1  response register holds a result.
- `resp_ready_i`  in  1  consumer takes the response.
- `resp_id_o`  out  1  index of the requester that owns the response.
- `resp_result_o`  out  DATA_WIDTH  registered ALU result.
- `resp_flag_o`  out  1  registered ALU flag.
- `ops_cnt_o`  out  16  count of delivered responses; wraps 0xFFFF→0.

## Operation
- Slot states `EMPTY` and `FULL` (`resp_valid_o` = state==`FULL`).
- `can_issue` = `EMPTY` | (`FULL` & `resp_ready_i`).
- Grant (combinational):
  - If only one requester is valid, it wins.
  - If both are valid, `prio` (1 bit) wins.
  - If neither is valid, there is no grant.
- `req_ready_o[i]` = grant[i] & `can_issue`. Ready may depend on `req_valid_i`; there are no other combinational input→output paths.
- A request is accepted when `req_valid_i[i]` & `req_ready_o[i]`.
- On accept:
  - The muxed a/b/op drive the ALU.
  - `resp_result_o`/`resp_flag_o` load the ALU outputs and `resp_id_o` loads i.
  - State→`FULL`.
  - `prio` ← ~i.
- Without a grant, `prio` is unchanged.
- Transitions:
  - `EMPTY` + accept → `FULL`.
  - `FULL` + `resp_ready_i` + accept → `FULL` with new data (back-to-back).
  - `FULL` + `resp_ready_i`, no accept → `EMPTY`.
  - `FULL`, no `resp_ready_i` → hold all response outputs stable.
- `ops_cnt_o` increments by 1 on each `resp_valid_o` & `resp_ready_i` and wraps modulo 2^16.
- Requester rules: hold valid and payload stable until accepted; valid must not depend on ready.
- Consumer rules: `resp_ready_i` may be held high permanently.
- Arithmetic, width and opcode behaviour are exactly those of `alu_riscv`; unknown opcodes give result 0, flag 0, and are still delivered.
- Reset (any time, including with `FULL` and the consumer stalled):
  - State `EMPTY`, `prio`=0.
  - `resp_result_o`=0, `resp_flag_o`=0, `resp_id_o`=0, `ops_cnt_o`=0.
  - Any pending response is dropped and not counted.

## Timing
- Latency is 1 cycle: accepted at edge N, `resp_valid_o` high after edge N.
- Throughput is 1 op/cycle with `resp_ready_i`=1 and at least one requester valid.
- With both requesters valid continuously, grants alternate 0,1,0,1…; the first grant after reset goes to requester 0.
- Worst-case wait from a requester's first valid cycle to acceptance is 2 cycles when the consumer is always ready.
- Reset values: `req_ready_o` is 0 while `rst_i` is high and otherwise purely combinational. `resp_valid_o`=0, `resp_id_o`=0, `resp_result_o`=0, `resp_flag_o`=0, `ops_cnt_o`=0.
- No output changes while `FULL` and `resp_ready_i`=0, other than `req_ready_o`, which stays 0.

## Structure
- Shared package `alu_arb_pkg`:
  - `NUM_REQ`=2.
  - `typedef logic req_id_t`.
  - `typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t`.
  - `OPS_CNT_W`=16.
- Opcodes are imported from `alu_opcodes_pkg`.
- Sub-module `rr_arbiter2`: inputs `req[1:0]`, `prio`; outputs one-hot `grant[1:0]`, `grant_id`. It is purely combinational, with `prio` held in the parent.
- One `alu_riscv` instance in the parent, fed by a 2:1 operand/op mux on `grant_id`.

## Test plan
- Reset, then requester 0 sends ALU_ADD a=5 b=7 with `resp_ready_i`=1 → next cycle `resp_valid_o`=1, id=0, result=12, flag=0; `ops_cnt_o`=1 one cycle later.
- Both valid continuously with 4 ops each (ALU_SUB 10-3 on req0, ALU_EQ 9==9 on req1), consumer always ready → ids 0,1,0,1,…; results 7 / flag 1 alternate; 8 ops complete in 8 consecutive cycles.
- Consumer stalls for 3 cycles with `FULL` holding ALU_SLTU a=1 b=0xFFFFFFFF → result 1 held stable, both `req_ready_o`=0; release → the next request is accepted in the same cycle as the handoff.
- Assert `rst_i` mid-stall with `FULL`, id=1, result=0xDEADBEEF → all outputs zero immediately (asynchronous); after release the first grant with both valid goes to requester 0; `ops_cnt_o`=0.
- 65536 single-op transactions → `ops_cnt_o` wraps to 0 on the last handoff.
- Illegal opcode 5'b11111 from requester 1 → response delivered with result 0, flag 0, id=1.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Types and constants shared by the ALU share arbiter and its arbiter.
package alu_arb_pkg;

  localparam int unsigned NUM_REQ   = 2;
  localparam int unsigned OPS_CNT_W = 16;

  typedef logic req_id_t;

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;

endpackage

// File: rtl/alu_opcodes_pkg.sv
// Opcode encoding shared by alu_riscv and anything that drives it.
package alu_opcodes_pkg;

  localparam logic [4:0] ALU_ADD  = 5'h00;
  localparam logic [4:0] ALU_SUB  = 5'h01;
  localparam logic [4:0] ALU_SLL  = 5'h02;
  localparam logic [4:0] ALU_SLT  = 5'h03;
  localparam logic [4:0] ALU_SLTU = 5'h04;
  localparam logic [4:0] ALU_XOR  = 5'h05;
  localparam logic [4:0] ALU_SRL  = 5'h06;
  localparam logic [4:0] ALU_SRA  = 5'h07;
  localparam logic [4:0] ALU_OR   = 5'h08;
  localparam logic [4:0] ALU_AND  = 5'h09;
  localparam logic [4:0] ALU_EQ   = 5'h10;
  localparam logic [4:0] ALU_NE   = 5'h11;
  localparam logic [4:0] ALU_LT   = 5'h12;
  localparam logic [4:0] ALU_GE   = 5'h13;
  localparam logic [4:0] ALU_LTU  = 5'h14;
  localparam logic [4:0] ALU_GEU  = 5'h15;

endpackage

// File: rtl/alu_riscv.sv
// Combinational RISC-V style ALU: arithmetic ops drive result, branch
// compares drive flag. Unknown opcodes give result 0 and flag 0.
module alu_riscv
  import alu_opcodes_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [4:0]            alu_op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  flag_o
);

  localparam int unsigned SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0] shamt;
  assign shamt = b_i[SHW-1:0];

  // Opcode decode and datapath
  always_comb begin
    result_o = '0;
    flag_o   = 1'b0;
    case (alu_op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SLT:  result_o = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: result_o = {{(DATA_WIDTH-1){1'b0}}, (a_i < b_i)};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $signed(a_i) >>> shamt;
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_EQ:   flag_o   = (a_i == b_i);
      ALU_NE:   flag_o   = (a_i != b_i);
      ALU_LT:   flag_o   = ($signed(a_i) < $signed(b_i));
      ALU_GE:   flag_o   = ($signed(a_i) >= $signed(b_i));
      ALU_LTU:  flag_o   = (a_i < b_i);
      ALU_GEU:  flag_o   = (a_i >= b_i);
      default: begin
        result_o = '0;
        flag_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way combinational round-robin arbiter; priority state lives in the parent.
module rr_arbiter2
  import alu_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] grant,
  output req_id_t    grant_id
);

  // Lone requester wins; on contention the prio index wins
  always_comb begin
    grant = req;
    if (req == 2'b11) grant = prio ? 2'b10 : 2'b01;
  end

  assign grant_id = grant[1];

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one alu_riscv between two requesters with a one-entry tagged
// response register; full throughput when the consumer is always ready.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_a_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_b_i,
  input  logic [NUM_REQ-1:0][4:0]             req_op_i,
  output logic                                resp_valid_o,
  input  logic                                resp_ready_i,
  output logic                                resp_id_o,
  output logic [DATA_WIDTH-1:0]               resp_result_o,
  output logic                                resp_flag_o,
  output logic [OPS_CNT_W-1:0]                ops_cnt_o
);

  slot_state_t           state_q, state_d;
  logic                  prio_q, prio_d;
  req_id_t               id_q, id_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  flag_q, flag_d;
  logic [OPS_CNT_W-1:0]  cnt_q, cnt_d;

  logic [1:0]            grant;
  req_id_t               grant_id;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_flag;
  logic                  can_issue;
  logic                  accept;
  logic                  handoff;

  rr_arbiter2 u_arb (
    .req      (req_valid_i),
    .prio     (prio_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

  alu_riscv #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .alu_op_i (req_op_i[grant_id]),
    .a_i      (req_a_i[grant_id]),
    .b_i      (req_b_i[grant_id]),
    .result_o (alu_result),
    .flag_o   (alu_flag)
  );

  assign handoff     = (state_q == SLOT_FULL) & resp_ready_i;
  assign can_issue   = (state_q == SLOT_EMPTY) | resp_ready_i;
  assign req_ready_o = rst_i ? '0 : (grant & {2{can_issue}});
  assign accept      = |(req_valid_i & req_ready_o);

  // Slot, response payload, round-robin pointer and delivery counter next state
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    id_d     = id_q;
    result_d = result_q;
    flag_d   = flag_q;
    cnt_d    = cnt_q + OPS_CNT_W'(handoff);
    if (accept) begin
      state_d  = SLOT_FULL;
      prio_d   = ~grant_id;
      id_d     = grant_id;
      result_d = alu_result;
      flag_d   = alu_flag;
    end else if (handoff) begin
      state_d  = SLOT_EMPTY;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= SLOT_EMPTY;
      prio_q   <= 1'b0;
      id_q     <= 1'b0;
      result_q <= '0;
      flag_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      id_q     <= id_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      cnt_q    <= cnt_d;
    end
  end

  assign resp_valid_o  = (state_q == SLOT_FULL);
  assign resp_id_o     = id_q;
  assign resp_result_o = result_q;
  assign resp_flag_o   = flag_q;
  assign ops_cnt_o     = cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter.
module tb_alu_share_arbiter;
  import alu_opcodes_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0][4:0]  req_op;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [31:0]      resp_result;
  logic             resp_flag;
  logic [15:0]      ops_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_WIDTH(32)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_a_i       (req_a),
    .req_b_i       (req_b),
    .req_op_i      (req_op),
    .resp_valid_o  (resp_valid),
    .resp_ready_i  (resp_ready),
    .resp_id_o     (resp_id),
    .resp_result_o (resp_result),
    .resp_flag_o   (resp_flag),
    .ops_cnt_o     (ops_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = '0;
    resp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    resp_ready = 1'b1;
    step();
    step();
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready got %b exp 00", req_ready);
    end
    checks++;
    if ({resp_valid, resp_id, resp_flag, resp_result, ops_cnt} !== 51'd0) begin
      errors++;
      $display("FAIL reset_outputs got v%b id%b f%b r%h c%h exp all zero",
               resp_valid, resp_id, resp_flag, resp_result, ops_cnt);
    end
    req_valid = '0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_add();
    req_a[0] = 32'd5;
    req_b[0] = 32'd7;
    req_op[0] = ALU_ADD;
    req_valid = 2'b01;
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL add_ready got %b exp 01", req_ready);
    end
    step();
    req_valid = '0;
    checks++;
    if ({resp_valid, resp_id, resp_flag, resp_result} !== {1'b1, 1'b0, 1'b0, 32'd12}) begin
      errors++;
      $display("FAIL add_resp got v%b id%b f%b r%h exp v1 id0 f0 r0000000c",
               resp_valid, resp_id, resp_flag, resp_result);
    end
    checks++;
    if (ops_cnt !== 16'd0) begin
      errors++;
      $display("FAIL add_cnt_before got %0d exp 0", ops_cnt);
    end
    step();
    checks++;
    if ({resp_valid, ops_cnt} !== {1'b0, 16'd1}) begin
      errors++;
      $display("FAIL add_cnt_after got v%b c%0d exp v0 c1", resp_valid, ops_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_ready;
    logic [31:0] exp_res;
    apply_reset();
    req_a[0] = 32'd10; req_b[0] = 32'd3; req_op[0] = ALU_SUB;
    req_a[1] = 32'd9;  req_b[1] = 32'd9; req_op[1] = ALU_EQ;
    req_valid = 2'b11;
    resp_ready = 1'b1;
    #1;
    for (int unsigned k = 0; k < 8; k++) begin
      exp_ready = k[0] ? 2'b10 : 2'b01;
      exp_res   = k[0] ? 32'd0 : 32'd7;
      checks++;
      if (req_ready !== exp_ready) begin
        errors++;
        $display("FAIL b2b_ready[%0d] got %b exp %b", k, req_ready, exp_ready);
      end
      step();
      checks++;
      if ({resp_valid, resp_id, resp_flag, resp_result} !== {1'b1, k[0], k[0], exp_res}) begin
        errors++;
        $display("FAIL b2b_resp[%0d] got v%b id%b f%b r%h exp v1 id%b f%b r%h",
                 k, resp_valid, resp_id, resp_flag, resp_result, k[0], k[0], exp_res);
      end
    end
    req_valid = '0;
    step();
    checks++;
    if ({resp_valid, ops_cnt} !== {1'b0, 16'd8}) begin
      errors++;
      $display("FAIL b2b_cnt got v%b c%0d exp v0 c8", resp_valid, ops_cnt);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    req_a[0] = 32'd1; req_b[0] = 32'hFFFF_FFFF; req_op[0] = ALU_SLTU;
    req_valid = 2'b01;
    resp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL stall_first_ready got %b exp 01", req_ready);
    end
    step();
    req_a[1] = 32'd2; req_b[1] = 32'd3; req_op[1] = ALU_ADD;
    req_valid = 2'b10;
    #1;
    for (int unsigned i = 0; i < 3; i++) begin
      checks++;
      if (req_ready !== 2'b00) begin
        errors++;
        $display("FAIL stall_ready[%0d] got %b exp 00", i, req_ready);
      end
      checks++;
      if ({resp_valid, resp_id, resp_flag, resp_result, ops_cnt} !==
          {1'b1, 1'b0, 1'b0, 32'd1, 16'd0}) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v%b id%b f%b r%h c%0d exp v1 id0 f0 r00000001 c0",
                 i, resp_valid, resp_id, resp_flag, resp_result, ops_cnt);
      end
      step();
    end
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL stall_release_ready got %b exp 10", req_ready);
    end
    step();
    req_valid = '0;
    checks++;
    if ({resp_valid, resp_id, resp_flag, resp_result, ops_cnt} !==
        {1'b1, 1'b1, 1'b0, 32'd5, 16'd1}) begin
      errors++;
      $display("FAIL stall_handoff got v%b id%b f%b r%h c%0d exp v1 id1 f0 r00000005 c1",
               resp_valid, resp_id, resp_flag, resp_result, ops_cnt);
    end
    step();
    checks++;
    if ({resp_valid, ops_cnt} !== {1'b0, 16'd2}) begin
      errors++;
      $display("FAIL stall_drain got v%b c%0d exp v0 c2", resp_valid, ops_cnt);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req_a[1] = 32'hDEAD_BEEF; req_b[1] = 32'd0; req_op[1] = ALU_ADD;
    req_valid = 2'b10;
    resp_ready = 1'b0;
    step();
    checks++;
    if ({resp_valid, resp_id, resp_flag, resp_result} !== {1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL arst_load got v%b id%b f%b r%h exp v1 id1 f0 rdeadbeef",
               resp_valid, resp_id, resp_flag, resp_result);
    end
    req_valid = 2'b11;
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({resp_valid, resp_id, resp_flag, resp_result, ops_cnt} !== 51'd0) begin
      errors++;
      $display("FAIL arst_outputs got v%b id%b f%b r%h c%0d exp all zero",
               resp_valid, resp_id, resp_flag, resp_result, ops_cnt);
    end
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL arst_ready got %b exp 00", req_ready);
    end
    step();
    rst = 1'b0;
    req_a[0] = 32'd1; req_b[0] = 32'd1; req_op[0] = ALU_ADD;
    req_a[1] = 32'd2; req_b[1] = 32'd2; req_op[1] = ALU_ADD;
    req_valid = 2'b11;
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL arst_first_grant got %b exp 01", req_ready);
    end
    step();
    checks++;
    if ({resp_valid, resp_id, resp_result, ops_cnt} !== {1'b1, 1'b0, 32'd2, 16'd0}) begin
      errors++;
      $display("FAIL arst_first_resp got v%b id%b r%h c%0d exp v1 id0 r00000002 c0",
               resp_valid, resp_id, resp_result, ops_cnt);
    end
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL arst_second_grant got %b exp 10", req_ready);
    end
    step();
    req_valid = '0;
    checks++;
    if ({resp_valid, resp_id, resp_result, ops_cnt} !== {1'b1, 1'b1, 32'd4, 16'd1}) begin
      errors++;
      $display("FAIL arst_second_resp got v%b id%b r%h c%0d exp v1 id1 r00000004 c1",
               resp_valid, resp_id, resp_result, ops_cnt);
    end
    step();
  endtask

  task automatic test_illegal_op();
    req_a[1] = 32'd123; req_b[1] = 32'd456; req_op[1] = 5'b11111;
    req_valid = 2'b10;
    resp_ready = 1'b1;
    #1;
    step();
    req_valid = '0;
    checks++;
    if ({resp_valid, resp_id, resp_flag, resp_result} !== {1'b1, 1'b1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL illegal_resp got v%b id%b f%b r%h exp v1 id1 f0 r00000000",
               resp_valid, resp_id, resp_flag, resp_result);
    end
    step();
  endtask

  task automatic test_cnt_wrap();
    apply_reset();
    req_a[0] = 32'd1; req_b[0] = 32'd1; req_op[0] = ALU_ADD;
    req_valid = 2'b01;
    resp_ready = 1'b1;
    for (int unsigned i = 0; i < 65536; i++) step();
    req_valid = '0;
    checks++;
    if ({resp_valid, ops_cnt} !== {1'b1, 16'hFFFF}) begin
      errors++;
      $display("FAIL wrap_before got v%b c%h exp v1 cffff", resp_valid, ops_cnt);
    end
    step();
    checks++;
    if ({resp_valid, ops_cnt} !== {1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL wrap_after got v%b c%h exp v0 c0000", resp_valid, ops_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_stall();
    test_async_reset();
    test_illegal_op();
    test_cnt_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
